edge_event_arbiter: RTL and testbench

- Multi-channel edge-event controller.
- Runs one registered edge detector per input channel, each configurable for rising, falling or both edges.
- Holds detected events as per-channel pending flags and round-robin arbitrates them onto a single valid/ready event stream for downstream logic (interrupt aggregator, event FIFO).
- Counts events dropped because a channel's pending slot was still occupied.

---
 rtl/edge_event_arbiter_if.sv | 25 ++
 rtl/edge_event_arbiter.sv | 161 ++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_event_arbiter_if.sv
// Event stream between the edge-event arbiter and its consumer
// (interrupt aggregator, event FIFO). One event moves per cycle
// in which evt_valid and evt_ready are both high.
interface edge_event_arbiter_if #(
  parameter int CH_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_pol;

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_pol,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_pol,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel edge detectors feed
// pending flags that are round-robin arbitrated onto one valid/ready stream.
// Edges that land on an occupied pending slot bump a saturating drop counter.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no event offered; grants the next pending channel if any
// OFFER | evt_ch/evt_pol held on the stream until the consumer accepts
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              enable,
  input  logic [N_CH-1:0]   din,
  input  logic [N_CH-1:0]   cfg_pos_en,
  input  logic [N_CH-1:0]   cfg_neg_en,
  edge_event_arbiter_if.master ev,
  output logic [N_CH-1:0]   pend,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              drop_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [N_CH-1:0] d_ff;
  logic [N_CH-1:0] pol;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] edge_det;
  logic [N_CH-1:0] eff_pend;
  logic [N_CH-1:0] gnt_oh;

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W-1:0] rr_next;
  logic [CH_W-1:0] evt_ch_q;
  logic [CH_W:0]   cand;
  logic            evt_pol_q;
  logic            gnt_found;
  logic            do_grant;
  logic            drop_any;

  assign rise     = din & ~d_ff & cfg_pos_en & {N_CH{enable}};
  assign fall     = ~din & d_ff & cfg_neg_en & {N_CH{enable}};
  assign edge_det = rise | fall;

  // While disabled the pending flags are being flushed, so nothing new is granted.
  assign eff_pend = pend & {N_CH{enable}};

  assign ev.evt_valid = (state_q == OFFER);
  assign ev.evt_ch    = evt_ch_q;
  assign ev.evt_pol   = evt_pol_q;

  assign rr_next  = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
  assign drop_any = |(edge_det & pend & ~gnt_oh);

  // Round-robin search: first pending channel at or above rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = {1'b0, rr_ptr} + (CH_W + 1)'(k);
      if (cand >= (CH_W + 1)'(N_CH)) begin
        cand = cand - (CH_W + 1)'(N_CH);
      end
      if (!gnt_found && eff_pend[cand[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[CH_W-1:0];
      end
    end
  end

  // Next state and grant decision; a handshake in OFFER can reload back-to-back.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          do_grant = 1'b1;
          state_d  = OFFER;
        end
      end
      OFFER: begin
        if (ev.evt_ready) begin
          do_grant = gnt_found;
          state_d  = gnt_found ? OFFER : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot view of the grant for the per-channel pending update.
  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      gnt_oh[i] = do_grant && (gnt_idx == CH_W'(i));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Edge history, pending slots, round-robin pointer and the offered event.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      d_ff      <= '0;
      pend      <= '0;
      pol       <= '0;
      rr_ptr    <= '0;
      evt_ch_q  <= '0;
      evt_pol_q <= 1'b0;
    end else begin
      d_ff <= din;
      for (int i = 0; i < N_CH; i++) begin
        if (!enable) begin
          pend[i] <= 1'b0;
        end else if (edge_det[i] && (!pend[i] || gnt_oh[i])) begin
          pend[i] <= 1'b1;
          pol[i]  <= rise[i];
        end else if (gnt_oh[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (do_grant) begin
        evt_ch_q  <= gnt_idx;
        evt_pol_q <= pol[gnt_idx];
        rr_ptr    <= rr_next;
      end
    end
  end

  // Saturating drop counter; clear wins over a same-cycle drop.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= '0;
    end else if (drop_any && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus a randomized run,
// every cycle compared against a behavioural model of the event rules.
module tb_edge_event_arbiter;
  localparam int N_CH    = 4;
  localparam int CH_W    = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             srst_n;
  logic             enable;
  logic [N_CH-1:0]  din;
  logic [N_CH-1:0]  cfg_pos_en;
  logic [N_CH-1:0]  cfg_neg_en;
  logic [N_CH-1:0]  pend;
  logic [CNT_W-1:0] drop_cnt;
  logic             drop_clr;

  edge_event_arbiter_if #(.CH_W(CH_W)) ev_if();

  edge_event_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .srst_n    (srst_n),
    .enable    (enable),
    .din       (din),
    .cfg_pos_en(cfg_pos_en),
    .cfg_neg_en(cfg_neg_en),
    .ev        (ev_if),
    .pend      (pend),
    .drop_cnt  (drop_cnt),
    .drop_clr  (drop_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit m_pend[N_CH];
  bit m_pol[N_CH];
  bit m_prev[N_CH];
  int m_rr;
  bit m_valid;
  int m_ch;
  bit m_opol;
  int m_cnt;

  // accepted events, in delivery order
  int log_ch[$];
  int log_pol[$];
  int n_valid_seen;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_pend[i] = 0;
      m_pol[i]  = 0;
      m_prev[i] = 0;
    end
    m_rr    = 0;
    m_valid = 0;
    m_ch    = 0;
    m_opol  = 0;
    m_cnt   = 0;
  endtask

  task automatic model_update();
    int gnt;
    int c;
    bit any_drop;
    bit r;
    bit f;
    gnt = -1;
    any_drop = 0;
    if (!srst_n) begin
      model_reset();
      return;
    end
    if (enable && (!m_valid || ev_if.evt_ready)) begin
      for (int k = 0; k < N_CH; k++) begin
        c = (m_rr + k) % N_CH;
        if (gnt < 0 && m_pend[c]) gnt = c;
      end
    end
    if (m_valid && ev_if.evt_ready) m_valid = 0;
    if (gnt >= 0) begin
      m_valid = 1;
      m_ch    = gnt;
      m_opol  = m_pol[gnt];
      m_rr    = (gnt + 1) % N_CH;
    end
    for (int i = 0; i < N_CH; i++) begin
      r = enable && din[i] && !m_prev[i] && cfg_pos_en[i];
      f = enable && !din[i] && m_prev[i] && cfg_neg_en[i];
      if (!enable) begin
        m_pend[i] = 0;
      end else if (r || f) begin
        if (!m_pend[i] || i == gnt) begin
          m_pend[i] = 1;
          m_pol[i]  = r;
        end else begin
          any_drop = 1;
        end
      end else if (i == gnt) begin
        m_pend[i] = 0;
      end
      m_prev[i] = din[i];
    end
    if (drop_clr) m_cnt = 0;
    else if (any_drop && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic compare_all();
    int pv;
    pv = 0;
    for (int i = 0; i < N_CH; i++) if (m_pend[i]) pv |= (1 << i);
    check_val("evt_valid", int'(ev_if.evt_valid), int'(m_valid));
    if (m_valid) begin
      check_val("evt_ch", int'(ev_if.evt_ch), m_ch);
      check_val("evt_pol", int'(ev_if.evt_pol), int'(m_opol));
    end
    check_val("pend", int'(pend), pv);
    check_val("drop_cnt", int'(drop_cnt), m_cnt);
  endtask

  // One clock: note any handshake, advance the model, compare after the edge.
  task automatic step();
    bit hs;
    int hc;
    int hp;
    hs = ev_if.evt_valid && ev_if.evt_ready;
    hc = int'(ev_if.evt_ch);
    hp = int'(ev_if.evt_pol);
    @(posedge clk);
    if (hs && srst_n) begin
      log_ch.push_back(hc);
      log_pol.push_back(hp);
    end
    model_update();
    #1;
    compare_all();
    if (ev_if.evt_valid) n_valid_seen++;
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    step();
    srst_n = 1'b1;
  endtask

  task automatic clear_log();
    log_ch.delete();
    log_pol.delete();
    n_valid_seen = 0;
  endtask

  initial begin
    srst_n          = 1'b0;
    enable          = 1'b0;
    din             = '0;
    cfg_pos_en      = '0;
    cfg_neg_en      = '0;
    drop_clr        = 1'b0;
    ev_if.evt_ready = 1'b0;
    n_valid_seen    = 0;
    model_reset();

    #2;
    check_val("rst_valid", int'(ev_if.evt_valid), 0);
    check_val("rst_pend", int'(pend), 0);
    check_val("rst_drop", int'(drop_cnt), 0);
    repeat (2) step();
    srst_n = 1'b1;

    // single rising edge, two-cycle latency, one-cycle offer
    enable          = 1'b1;
    cfg_pos_en      = 4'b0001;
    ev_if.evt_ready = 1'b1;
    repeat (2) step();
    din[0] = 1'b1;
    step();
    check_val("lat_pend", int'(pend), 1);
    check_val("lat_novalid", int'(ev_if.evt_valid), 0);
    step();
    check_val("lat_valid", int'(ev_if.evt_valid), 1);
    check_val("lat_ch", int'(ev_if.evt_ch), 0);
    check_val("lat_pol", int'(ev_if.evt_pol), 1);
    step();
    check_val("single_pulse", int'(ev_if.evt_valid), 0);
    check_val("single_drop", int'(drop_cnt), 0);

    // both-edge channel 2 with a one-cycle pulse
    cfg_pos_en = 4'b0100;
    cfg_neg_en = 4'b0100;
    clear_log();
    din[2] = 1'b1;
    step();
    din[2] = 1'b0;
    repeat (5) step();
    check_val("both_n", log_ch.size(), 2);
    if (log_ch.size() == 2) begin
      check_val("both_ch0", log_ch[0], 2);
      check_val("both_pol0", log_pol[0], 1);
      check_val("both_ch1", log_ch[1], 2);
      check_val("both_pol1", log_pol[1], 0);
    end
    check_val("both_drop", int'(drop_cnt), 0);

    // round robin from a fresh pointer, no bubbles
    din = '0;
    do_reset();
    cfg_pos_en = 4'b1111;
    cfg_neg_en = 4'b0000;
    repeat (2) step();
    clear_log();
    din = 4'b1111;
    step();
    n_valid_seen = 0;
    repeat (7) step();
    check_val("rr_valid_cycles", n_valid_seen, 4);
    check_val("rr_n", log_ch.size(), 4);
    if (log_ch.size() == 4) begin
      for (int i = 0; i < 4; i++) check_val("rr_order", log_ch[i], i);
    end

    // backpressure: first edge offered, second pending, third dropped
    din = '0;
    repeat (2) step();
    cfg_pos_en      = 4'b0010;
    cfg_neg_en      = 4'b0010;
    ev_if.evt_ready = 1'b0;
    clear_log();
    din[1] = 1'b1; step();
    din[1] = 1'b0; step();
    din[1] = 1'b1; step();
    check_val("bp_drop", int'(drop_cnt), 1);
    check_val("bp_pend1", int'(pend[1]), 1);
    repeat (3) step();
    check_val("bp_stall_ch", int'(ev_if.evt_ch), 1);
    check_val("bp_stall_pol", int'(ev_if.evt_pol), 1);
    ev_if.evt_ready = 1'b1;
    repeat (4) step();
    check_val("bp_n", log_ch.size(), 2);
    if (log_ch.size() == 2) begin
      check_val("bp_pol0", log_pol[0], 1);
      check_val("bp_pol1", log_pol[1], 0);
    end

    // saturation and clear-beats-increment
    ev_if.evt_ready = 1'b0;
    for (int t = 0; t < 305; t++) begin
      din[1] = ~din[1];
      step();
    end
    check_val("sat_max", int'(drop_cnt), CNT_MAX);
    din[1]   = ~din[1];
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    check_val("sat_clr", int'(drop_cnt), 0);
    ev_if.evt_ready = 1'b1;
    repeat (5) step();

    // enabling with a high input must not fake an edge
    enable     = 1'b0;
    cfg_pos_en = 4'b0001;
    cfg_neg_en = 4'b0000;
    din        = '0;
    repeat (2) step();
    clear_log();
    din[0] = 1'b1;
    repeat (2) step();
    enable = 1'b1;
    repeat (4) step();
    check_val("en_noevt", log_ch.size(), 0);

    // reset in the middle of an offer
    ev_if.evt_ready = 1'b0;
    cfg_pos_en      = 4'b1100;
    din             = 4'b1100;
    repeat (3) step();
    check_val("mid_valid", int'(ev_if.evt_valid), 1);
    srst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", int'(ev_if.evt_valid), 0);
    check_val("mid_rst_pend", int'(pend), 0);
    din = '0;
    step();
    srst_n          = 1'b1;
    cfg_pos_en      = 4'b1111;
    ev_if.evt_ready = 1'b1;
    step();
    clear_log();
    din = 4'b1111;
    repeat (6) step();
    check_val("post_rst_n", log_ch.size(), 4);
    if (log_ch.size() > 0) check_val("post_rst_first", log_ch[0], 0);

    // randomized traffic, occasional config changes, disables, clears, resets
    for (int t = 0; t < 800; t++) begin
      din             = N_CH'($urandom);
      ev_if.evt_ready = ($urandom_range(0, 3) != 0);
      enable          = ($urandom_range(0, 19) != 0);
      drop_clr        = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) begin
        cfg_pos_en = N_CH'($urandom);
        cfg_neg_en = N_CH'($urandom);
      end
      srst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    srst_n   = 1'b1;
    drop_clr = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
